// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter.
//   tx_state_t      : transmitter FSM state encoding
//   STOP_SEL_*      : encodings of the stop_sel configuration input
//   STOP_TICKS_*    : stop-phase lengths in oversampling ticks
//   SB_TICK         : oversampling ticks per start/data/parity bit
//   stop_last_tick  : terminal tick-counter value for a stop_sel setting
package uart_pkg;

    localparam int SB_TICK = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] STOP_SEL_1     = 2'b00;
    localparam logic [1:0] STOP_SEL_1P5   = 2'b01;
    localparam logic [1:0] STOP_SEL_2     = 2'b10;
    localparam logic [1:0] STOP_SEL_2_ALT = 2'b11;

    localparam int STOP_TICKS_1   = 16;
    localparam int STOP_TICKS_1P5 = 24;
    localparam int STOP_TICKS_2   = 32;

    // Both 1x encodings select two stop bits.
    function automatic logic [4:0] stop_last_tick(input logic [1:0] sel);
        case (sel)
            STOP_SEL_1:   return 5'(STOP_TICKS_1 - 1);
            STOP_SEL_1P5: return 5'(STOP_TICKS_1P5 - 1);
            default:      return 5'(STOP_TICKS_2 - 1);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every dvsr+1 clocks.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   clr   : restart the count so the first tick lands dvsr clocks later
//   dvsr  : divisor (0 = tick every clock)
//   tick  : one-cycle oversampling tick
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] r_cnt;

    assign tick = (r_cnt == dvsr);

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, 7/8 data bits LSB first, optional
// even/odd parity, 1 / 1.5 / 2 stop bits. Configuration is captured when a
// request is accepted, so input changes never disturb a frame in flight.
//   clk, reset    : system clock, synchronous active-high reset
//   dvsr          : baud divisor (tick every dvsr+1 clocks)
//   data_bits_7   : 1 = 7 data bits, 0 = 8
//   parity_en     : append parity bit
//   parity_even   : 1 = even, 0 = odd parity
//   stop_sel      : 00 = 1, 01 = 1.5, 1x = 2 stop bits
//   tx_start, din : send request and byte
//   tx_busy       : frame in progress (through the done cycle)
//   tx_done_tick  : one-cycle pulse after the last stop tick
//   tx            : registered serial line, idle high
//
// state     | meaning
// ----------+------------------------------------------
// ST_IDLE   | line high, waiting for tx_start
// ST_START  | start bit (0) for SB_TICK ticks
// ST_DATA   | shifting data bits out LSB first
// ST_PARITY | parity bit for SB_TICK ticks
// ST_STOP   | line high for 16/24/32 ticks
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int DVSR_W   = 11,
    parameter int SB_TICK  = uart_pkg::SB_TICK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              data_bits_7,
    input  logic              parity_en,
    input  logic              parity_even,
    input  logic [1:0]        stop_sel,
    input  logic              tx_start,
    input  logic [7:0]        din,
    output logic              tx_busy,
    output logic              tx_done_tick,
    output logic              tx
);

    localparam int BCNT_W = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;

    tx_state_t           r_state, w_state_next;
    logic [4:0]          r_tick_cnt, w_tick_cnt_next;
    logic [BCNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic [DBIT_MAX-1:0] r_shift, w_shift_next;
    logic                r_parity, w_parity_next;
    logic                r_tx, w_tx_next;
    logic                r_done, w_done_next;

    logic [DVSR_W-1:0]   r_dvsr;
    logic                r_bits7;
    logic                r_par_en;
    logic                r_par_even;
    logic [1:0]          r_stop_sel;

    logic                w_tick;
    logic                w_accept;
    logic                w_bit_end;
    logic                w_stop_end;
    logic [BCNT_W-1:0]   w_last_bit;

    // The done cycle is already in IDLE; a request seen then is dropped.
    assign w_accept   = (r_state == ST_IDLE) && !r_done && tx_start;
    assign w_bit_end  = w_tick && (r_tick_cnt == 5'(SB_TICK - 1));
    assign w_stop_end = w_tick && (r_tick_cnt == stop_last_tick(r_stop_sel));
    assign w_last_bit = r_bits7 ? BCNT_W'(DBIT_MAX - 2) : BCNT_W'(DBIT_MAX - 1);

    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .dvsr  (r_dvsr),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_parity_next   = r_parity;
        w_done_next     = 1'b0;
        w_tx_next       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next    = ST_START;
                    w_tick_cnt_next = '0;
                    w_bit_cnt_next  = '0;
                    w_shift_next    = DBIT_MAX'(din);
                    w_parity_next   = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next    = ST_DATA;
                    w_tick_cnt_next = '0;
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 5'd1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_tick_cnt_next = '0;
                    w_parity_next   = r_parity ^ r_shift[0];
                    w_shift_next    = r_shift >> 1;
                    if (r_bit_cnt == w_last_bit) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 5'd1;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next    = ST_STOP;
                    w_tick_cnt_next = '0;
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 5'd1;
                end
            end
            ST_STOP: begin
                if (w_stop_end) begin
                    w_state_next    = ST_IDLE;
                    w_tick_cnt_next = '0;
                    w_done_next     = 1'b1;
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 5'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line value is derived from the state being entered so tx can be
        // a plain register without a cycle of lag.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_parity_next ^ ~r_par_even;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_dvsr     <= '0;
            r_bits7    <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_stop_sel <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
            if (w_accept) begin
                r_dvsr     <= dvsr;
                r_bits7    <= data_bits_7;
                r_par_en   <= parity_en;
                r_par_even <= parity_even;
                r_stop_sel <= stop_sel;
            end
        end
    end

    assign tx           = r_tx;
    assign tx_done_tick = r_done;
    assign tx_busy      = (r_state != ST_IDLE) || r_done;

endmodule
